score_counter: RTL and testbench



---
 rtl/score_pkg.sv | 38 +++
 rtl/score_digit.sv | 31 +++
 rtl/score_counter.sv | 116 +++++++++++
 tb/tb_score_counter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and helpers for the score counter datapath.
package score_pkg;

  localparam int MAX_DIGITS = 6;
  localparam int RADIX_DEC  = 10;
  localparam int RADIX_HEX  = 16;

  typedef logic [3:0] digit_t;

  typedef enum logic {
    PLAY   = 1'b0,
    FROZEN = 1'b1
  } state_t;

  // Ripple +1 across the low n digits of a packed score, wrapping each digit at radix.
  function automatic logic [4*MAX_DIGITS-1:0] score_inc(
    input logic [4*MAX_DIGITS-1:0] value,
    input int                      n,
    input int                      radix
  );
    logic [4*MAX_DIGITS-1:0] result;
    logic                    carry;
    result = value;
    carry  = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n && carry) begin
        if (value[4*i +: 4] == digit_t'(radix - 1)) begin
          result[4*i +: 4] = 4'd0;
        end else begin
          result[4*i +: 4] = value[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/score_digit.sv
// One score digit: modulo-RADIX register with carry-in and carry-out.
module score_digit
  import score_pkg::*;
#(
  parameter int RADIX = RADIX_DEC
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   clr,
  input  logic   cin,
  output digit_t q,
  output logic   cout
);

  logic at_top;

  assign at_top = (q == digit_t'(RADIX - 1));
  assign cout   = cin & at_top;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (cin) begin
      q <= at_top ? digit_t'(0) : q + digit_t'(1);
    end
  end

endmodule

// File: rtl/score_counter.sv
// Multi-digit score counter with game-over freeze and sticky overflow.
// Optional high-score register enabled by defining SCORE_COUNTER_HIGH_SCORE_EN.
module score_counter
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int RADIX      = RADIX_DEC,
  parameter int SATURATE   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    point,
  input  logic                    clear,
  input  logic                    game_over,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    overflow,
  output logic                    frozen
`ifdef SCORE_COUNTER_HIGH_SCORE_EN
  ,
  output logic [4*NUM_DIGITS-1:0] high_score
`endif
);

  localparam logic SAT = (SATURATE != 0);

  state_t                state;
  logic                  point_q;
  logic                  inc;
  logic                  play;
  logic                  at_max;
  logic                  count_en;
  logic                  ovf_set;
  logic [NUM_DIGITS:0]   carry;

  assign inc      = point & ~point_q;
  assign play     = (state == PLAY);
  assign count_en = inc & play & ~(at_max & SAT);
  // In wrap mode the carry out of the top digit is exactly "incremented at maximum".
  assign ovf_set  = SAT ? (inc & play & at_max) : carry[NUM_DIGITS];
  assign carry[0] = count_en;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    at_max = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digits[4*i +: 4] != digit_t'(RADIX - 1)) at_max = 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    score_digit #(
      .RADIX (RADIX)
    ) u_digit (
      .clk   (clk),
      .reset (reset),
      .clr   (clear),
      .cin   (carry[i]),
      .q     (digits[4*i +: 4]),
      .cout  (carry[i+1])
    );
  end

  // point_q resets high so a point held through reset does not score.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= PLAY;
      frozen   <= 1'b0;
      point_q  <= 1'b1;
      overflow <= 1'b0;
    end else begin
      point_q <= point;
      if (clear)        overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
      case (state)
        PLAY: begin
          if (!clear && game_over) begin
            state  <= FROZEN;
            frozen <= 1'b1;
          end
        end
        FROZEN: begin
          if (clear) begin
            state  <= PLAY;
            frozen <= 1'b0;
          end
        end
        default: begin
          state  <= PLAY;
          frozen <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCORE_COUNTER_HIGH_SCORE_EN
  logic [4*MAX_DIGITS-1:0] cur_full;
  logic [4*MAX_DIGITS-1:0] post_full;
  logic [4*MAX_DIGITS-1:0] hs_full;
  logic                    to_frozen;

  assign cur_full  = (4*MAX_DIGITS)'(digits);
  assign hs_full   = (4*MAX_DIGITS)'(high_score);
  // The final point of a game scores on the same edge as the freeze, so compare the post-increment value.
  assign post_full = count_en ? score_inc(cur_full, NUM_DIGITS, RADIX) : cur_full;
  assign to_frozen = play & game_over & ~clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_score <= '0;
    end else if (to_frozen && (post_full > hs_full)) begin
      high_score <= post_full[4*NUM_DIGITS-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_score_counter.sv
// Directed self-checking bench for score_counter: default, wrap-mode and hex instances share stimulus.
module tb_score_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       point;
  logic       clear;
  logic       game_over;
  logic [7:0] digits,   digits_w,   digits_h;
  logic       overflow, overflow_w, overflow_h;
  logic       frozen,   frozen_w,   frozen_h;
`ifdef SCORE_COUNTER_HIGH_SCORE_EN
  logic [7:0] high_score, high_score_w, high_score_h;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  score_counter #(.NUM_DIGITS(2), .RADIX(10), .SATURATE(1)) dut (
    .clk(clk), .reset(reset), .point(point), .clear(clear), .game_over(game_over),
    .digits(digits), .overflow(overflow), .frozen(frozen)
`ifdef SCORE_COUNTER_HIGH_SCORE_EN
    , .high_score(high_score)
`endif
  );

  score_counter #(.NUM_DIGITS(2), .RADIX(10), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .point(point), .clear(clear), .game_over(game_over),
    .digits(digits_w), .overflow(overflow_w), .frozen(frozen_w)
`ifdef SCORE_COUNTER_HIGH_SCORE_EN
    , .high_score(high_score_w)
`endif
  );

  score_counter #(.NUM_DIGITS(2), .RADIX(16), .SATURATE(1)) dut_hex (
    .clk(clk), .reset(reset), .point(point), .clear(clear), .game_over(game_over),
    .digits(digits_h), .overflow(overflow_h), .frozen(frozen_h)
`ifdef SCORE_COUNTER_HIGH_SCORE_EN
    , .high_score(high_score_h)
`endif
  );

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; point = 1'b0; clear = 1'b0; game_over = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      @(negedge clk) point = 1'b1;
      @(negedge clk) point = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; point = 1'b1; clear = 1'b0; game_over = 1'b0;
    @(negedge clk);
    total++;
    if (digits !== 8'h00 || overflow !== 1'b0 || frozen !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got digits=%h ovf=%b frozen=%b want 00 0 0", digits, overflow, frozen);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (digits !== 8'h00) begin
      bad++;
      $display("FAIL point_held_through_reset: got %h want 00", digits);
    end
    point = 1'b0;
    @(negedge clk);
    total++;
    if (digits !== 8'h00) begin
      bad++;
      $display("FAIL point_drop_after_reset: got %h want 00", digits);
    end
  endtask

  task automatic test_basic();
    do_reset();
    pulse(3);
    total++;
    if (digits !== 8'h03 || overflow !== 1'b0 || frozen !== 1'b0) begin
      bad++;
      $display("FAIL three_points: got digits=%h ovf=%b frozen=%b want 03 0 0", digits, overflow, frozen);
    end
  endtask

  task automatic test_hold();
    @(negedge clk) point = 1'b1;
    repeat (10) @(negedge clk);
    point = 1'b0;
    @(negedge clk);
    total++;
    if (digits !== 8'h04) begin
      bad++;
      $display("FAIL held_point_once: got %h want 04", digits);
    end
  endtask

  task automatic test_carry();
    do_reset();
    pulse(9);
    total++;
    if (digits !== 8'h09) begin
      bad++;
      $display("FAIL preload_09: got %h want 09", digits);
    end
    @(negedge clk) point = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (digits !== 8'h10) begin
      bad++;
      $display("FAIL carry_latency: got %h want 10 right after edge", digits);
    end
    @(negedge clk) point = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    pulse(99);
    total++;
    if (digits !== 8'h99 || overflow !== 1'b0 || digits_w !== 8'h99) begin
      bad++;
      $display("FAIL reach_99: got sat=%h ovf=%b wrap=%h want 99 0 99", digits, overflow, digits_w);
    end
    pulse(1);
    total++;
    if (digits !== 8'h99 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL saturate: got digits=%h ovf=%b want 99 1", digits, overflow);
    end
    total++;
    if (digits_w !== 8'h00 || overflow_w !== 1'b1) begin
      bad++;
      $display("FAIL wrap: got digits=%h ovf=%b want 00 1", digits_w, overflow_w);
    end
    total++;
    if (digits_h !== 8'h64 || overflow_h !== 1'b0) begin
      bad++;
      $display("FAIL hex_100_points: got digits=%h ovf=%b want 64 0", digits_h, overflow_h);
    end
    pulse(1);
    total++;
    if (digits !== 8'h99 || overflow !== 1'b1 || digits_w !== 8'h01 || overflow_w !== 1'b1) begin
      bad++;
      $display("FAIL overflow_sticky: got sat=%h/%b wrap=%h/%b want 99/1 01/1", digits, overflow, digits_w, overflow_w);
    end
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    total++;
    if (digits !== 8'h00 || overflow !== 1'b0 || overflow_w !== 1'b0) begin
      bad++;
      $display("FAIL clear_overflow: got digits=%h ovf=%b ovf_w=%b want 00 0 0", digits, overflow, overflow_w);
    end
  endtask

  task automatic test_game_over();
    do_reset();
    pulse(5);
    @(negedge clk);
    point = 1'b1; game_over = 1'b1;
    @(negedge clk);
    point = 1'b0; game_over = 1'b0;
    total++;
    if (digits !== 8'h06 || frozen !== 1'b1) begin
      bad++;
      $display("FAIL final_point_then_freeze: got digits=%h frozen=%b want 06 1", digits, frozen);
    end
    pulse(2);
    @(negedge clk) game_over = 1'b1;
    @(negedge clk) game_over = 1'b0;
    total++;
    if (digits !== 8'h06 || frozen !== 1'b1) begin
      bad++;
      $display("FAIL frozen_ignores_points: got digits=%h frozen=%b want 06 1", digits, frozen);
    end
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    total++;
    if (digits !== 8'h00 || frozen !== 1'b0) begin
      bad++;
      $display("FAIL clear_unfreezes: got digits=%h frozen=%b want 00 0", digits, frozen);
    end
    pulse(3);
    @(negedge clk);
    point = 1'b1; clear = 1'b1;
    @(negedge clk);
    point = 1'b0; clear = 1'b0;
    total++;
    if (digits !== 8'h00) begin
      bad++;
      $display("FAIL clear_beats_point: got %h want 00", digits);
    end
    pulse(2);
    @(negedge clk);
    clear = 1'b1; game_over = 1'b1;
    @(negedge clk);
    clear = 1'b0; game_over = 1'b0;
    total++;
    if (digits !== 8'h00 || frozen !== 1'b0) begin
      bad++;
      $display("FAIL clear_beats_game_over: got digits=%h frozen=%b want 00 0", digits, frozen);
    end
    pulse(1);
    @(negedge clk) game_over = 1'b1;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; game_over = 1'b0;
    pulse(1);
    total++;
    if (digits !== 8'h01 || frozen !== 1'b0) begin
      bad++;
      $display("FAIL clear_game_over_in_frozen: got digits=%h frozen=%b want 01 0", digits, frozen);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse(42);
    @(negedge clk) game_over = 1'b1;
    @(negedge clk) game_over = 1'b0;
    total++;
    if (digits !== 8'h42 || frozen !== 1'b1) begin
      bad++;
      $display("FAIL reach_42: got digits=%h frozen=%b want 42 1", digits, frozen);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (digits !== 8'h00 || overflow !== 1'b0 || frozen !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got digits=%h ovf=%b frozen=%b want 00 0 0 before edge", digits, overflow, frozen);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_hex();
    do_reset();
    pulse(15);
    total++;
    if (digits_h !== 8'h0F) begin
      bad++;
      $display("FAIL hex_0f: got %h want 0f", digits_h);
    end
    pulse(1);
    total++;
    if (digits_h !== 8'h10 || digits !== 8'h16) begin
      bad++;
      $display("FAIL hex_carry: got hex=%h dec=%h want 10 16", digits_h, digits);
    end
  endtask

`ifdef SCORE_COUNTER_HIGH_SCORE_EN
  task automatic test_high_score();
    do_reset();
    pulse(11);
    @(negedge clk);
    point = 1'b1; game_over = 1'b1;
    @(negedge clk);
    point = 1'b0; game_over = 1'b0;
    total++;
    if (high_score !== 8'h12 || digits !== 8'h12) begin
      bad++;
      $display("FAIL high_score_game1: got hs=%h digits=%h want 12 12", high_score, digits);
    end
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    pulse(7);
    @(negedge clk) game_over = 1'b1;
    @(negedge clk) game_over = 1'b0;
    total++;
    if (high_score !== 8'h12 || digits !== 8'h07) begin
      bad++;
      $display("FAIL high_score_game2: got hs=%h digits=%h want 12 07", high_score, digits);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; point = 1'b0; clear = 1'b0; game_over = 1'b0;
    test_reset();
    test_basic();
    test_hold();
    test_carry();
    test_overflow();
    test_game_over();
    test_async_reset();
    test_hex();
`ifdef SCORE_COUNTER_HIGH_SCORE_EN
    test_high_score();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
